// File: rtl/sr_pkg.sv
// sr_pkg: shared debounce state encoding and default timing constants
package sr_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHK_HI = 2'd1,
        HIGH   = 2'd2,
        CHK_LO = 2'd3
    } deb_state_t;
    localparam int DEB_CYCLES_DEF = 4;
    localparam int CNT_W_DEF = 3;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser plus debounce FSM yielding a clean level and a rise pulse
module btn_debounce
    import sr_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic deb,
    output logic rise
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);
    logic s1, s2, rise_n;
    deb_state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            state <= IDLE;
            cnt <= '0;
            rise <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            state <= state_n;
            cnt <= cnt_n;
            rise <= rise_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        rise_n = 1'b0;
        case (state)
            IDLE: if (s2) begin
                state_n = CHK_HI;
                cnt_n = CNT_W'(1);
            end
            CHK_HI: if (!s2) begin
                state_n = IDLE;
                cnt_n = '0;
            end else if (cnt == LAST) begin
                state_n = HIGH;
                cnt_n = '0;
                rise_n = 1'b1;
            end else cnt_n = cnt + CNT_W'(1);
            HIGH: if (!s2) begin
                state_n = CHK_LO;
                cnt_n = CNT_W'(1);
            end
            CHK_LO: if (s2) begin
                state_n = HIGH;
                cnt_n = '0;
            end else if (cnt == LAST) begin
                state_n = IDLE;
                cnt_n = '0;
            end else cnt_n = cnt + CNT_W'(1);
            default: state_n = IDLE;
        endcase
    end
    assign deb = (state == HIGH) || (state == CHK_LO);
endmodule

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: debounced, arbitrated S/R command generator that never emits S=R=1
module sr_cmd_gen
    import sr_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int PRIO_SET = 0,
    parameter int PULSE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic clr_btn,
    output logic S,
    output logic R,
    output logic conflict
);
    localparam logic PS = PRIO_SET != 0;
    logic set_deb, set_rise, clr_deb, clr_rise, set_req, clr_req;
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_set (
        .clk(clk), .rst(rst), .btn(set_btn), .deb(set_deb), .rise(set_rise)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_clr (
        .clk(clk), .rst(rst), .btn(clr_btn), .deb(clr_deb), .rise(clr_rise)
    );
    assign set_req = (PULSE != 0) ? set_rise : set_deb;
    assign clr_req = (PULSE != 0) ? clr_rise : clr_deb;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            S <= 1'b0;
            R <= 1'b0;
            conflict <= 1'b0;
        end else begin
            S <= set_req & (~clr_req | PS);
            R <= clr_req & (~set_req | ~PS);
            conflict <= set_req & clr_req;
        end
    end
endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb_sr_cmd_gen: scoreboard bench comparing four parameter variants against a run-length debounce model
module tb_sr_cmd_gen;
    localparam int DEB = 4;
    logic clk = 1'b0, rst_n = 1'b0, set_btn = 1'b0, clr_btn = 1'b0;
    logic [3:0] s_o, r_o, c_o;
    int total = 0, bad = 0, pulses = 0;
    bit d1 [2], d2 [2], lvl [2], rq [2], dq [2];
    int run [2];
    logic [11:0] q [$];
    always #5 clk = ~clk;
    for (genvar i = 0; i < 4; i++) begin : g
        sr_cmd_gen #(.DEB_CYCLES(DEB), .CNT_W(3), .PRIO_SET(i % 2), .PULSE(i < 2 ? 1 : 0)) dut (
            .clk(clk), .rst(rst_n), .set_btn(set_btn), .clr_btn(clr_btn),
            .S(s_o[i]), .R(r_o[i]), .conflict(c_o[i])
        );
    end
    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            d1[c] = 0; d2[c] = 0; lvl[c] = 0; rq[c] = 0; dq[c] = 0; run[c] = 0;
        end
    endtask
    function automatic logic [11:0] expect_out();
        logic [11:0] e = '0;
        for (int i = 0; i < 4; i++) begin
            bit pulse = i < 2, prio = (i % 2) == 1;
            bit sq = pulse ? rq[0] : dq[0];
            bit cq = pulse ? rq[1] : dq[1];
            e[3*i +: 3] = {sq && (!cq || prio), cq && (!sq || !prio), sq && cq};
        end
        return e;
    endfunction
    always @(negedge rst_n) begin
        model_reset();
        q.delete();
    end
    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
            q.push_back('0);
        end else begin
            q.push_back(expect_out());
            for (int c = 0; c < 2; c++) begin
                rq[c] = 0;
                if (d2[c] != lvl[c]) begin
                    run[c]++;
                    if (run[c] == DEB) begin
                        lvl[c] = d2[c];
                        run[c] = 0;
                        rq[c] = lvl[c];
                    end
                end else run[c] = 0;
                dq[c] = lvl[c];
                d2[c] = d1[c];
            end
            d1[0] = set_btn;
            d1[1] = clr_btn;
        end
    end
    always @(negedge clk) begin
        logic [11:0] e;
        if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL queue_empty: no expected entry at %0t", $time);
        end else begin
            e = q.pop_front();
            for (int i = 0; i < 4; i++) begin
                total++;
                if ({s_o[i], r_o[i], c_o[i]} !== e[3*i +: 3]) begin
                    bad++;
                    $display("FAIL out_inst%0d at %0t: got S/R/c=%b expected %b", i, $time,
                             {s_o[i], r_o[i], c_o[i]}, e[3*i +: 3]);
                end
            end
        end
        total++;
        if ((s_o & r_o) !== 4'b0) begin
            bad++;
            $display("FAIL sr_both at %0t: S&R=%b expected 0000", $time, s_o & r_o);
        end
        pulses += int'(s_o[0]);
    end
    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask
    task automatic drive(input bit s, input bit c, input int n);
        set_btn = s;
        clr_btn = c;
        repeat (n) @(negedge clk);
    endtask
    initial begin
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        drive(0, 0, 6);
        pulses = 0;
        drive(1, 0, 30);
        drive(0, 0, 12);
        chk("hold_one_pulse", pulses, 1);
        drive(1, 0, 10);
        drive(0, 0, 12);
        chk("repress_second_pulse", pulses, 2);
        pulses = 0;
        drive(1, 0, 2);
        drive(0, 0, 1);
        drive(1, 0, 3);
        drive(0, 0, 12);
        chk("bounce_no_pulse", pulses, 0);
        drive(1, 1, 10);
        drive(0, 0, 12);
        drive(0, 1, 20);
        drive(1, 1, 20);
        drive(1, 0, 20);
        drive(0, 0, 12);
        set_btn = 1'b1;
        repeat (15) @(negedge clk);
        chk("pre_rst_level_held", int'(s_o[2]), 1);
        #1 rst_n = 1'b0;
        #1 chk("rst_async_clear", int'({s_o, r_o, c_o}), 0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        pulses = 0;
        repeat (20) @(negedge clk);
        drive(0, 0, 12);
        chk("post_rst_one_pulse", pulses, 1);
        for (int k = 0; k < 150; k++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 10));
            if ($urandom_range(0, 24) == 0) begin
                #1 rst_n = 1'b0;
                #1 chk("rand_rst_clear", int'({s_o, r_o, c_o}), 0);
                repeat ($urandom_range(1, 3)) @(negedge clk);
                #1 rst_n = 1'b1;
            end
        end
        drive(0, 0, 12);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sr_cmd_gen.md
Name: sr_cmd_gen

Overview:
- Upstream command stage for the SR flip-flop block.
- Turns two raw, bouncy, asynchronous push-button inputs (set, clear) into clean, registered, mutually exclusive S/R commands, ready to drive the flip-flop's S and R inputs directly.
- Synchronises each input, debounces it with a per-channel FSM and arbitrates simultaneous requests, so the forbidden S=R=1 input combination is never produced.

Parameters:
- DEB_CYCLES, 4: consecutive synchronised samples needed to accept a level change; legal range 2..(2^CNT_W - 1).
- CNT_W, 3: width of the debounce counter.
- PRIO_SET, 0: on simultaneous requests, 1 = set wins, 0 = clear wins.
- PULSE, 1: 1 = S/R is a single-cycle pulse per accepted press; 0 = S/R follows the debounced level while held.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- set_btn  in  1  raw set button, asynchronous to clk.
- clr_btn  in  1  raw clear button, asynchronous to clk.
- S  out  1  registered set command to the SR flip-flop.
- R  out  1  registered reset command to the SR flip-flop.
- conflict  out  1  registered flag: both requests were active in the same cycle and arbitration was applied.

Behaviour:
- Reset (rst=0, asynchronous):
  - sync flops, counters and FSMs go to 0 / IDLE.
  - S=0, R=0, conflict=0.
  - Release of reset is treated synchronously through the flops.
- Synchroniser: two flops per input. sync = second flop.
- Debounce FSM, one per channel, states IDLE, CHK_HI, HIGH, CHK_LO:
  - IDLE: if sync=1, go to CHK_HI with cnt=1.
  - CHK_HI: if sync=1 and cnt=DEB_CYCLES-1, go to HIGH and pulse rise for 1 cycle. Else if sync=1, cnt+1. Else (sync=0), back to IDLE with cnt=0.
  - HIGH: if sync=0, go to CHK_LO with cnt=1.
  - CHK_LO: if sync=0 and cnt=DEB_CYCLES-1, go to IDLE. Else if sync=0, cnt+1. Else back to HIGH with cnt=0.
  - deb = 1 in HIGH and CHK_LO.
  - cnt never wraps; it is cleared on every state change.
- Request: req = rise when PULSE=1; req = deb when PULSE=0.
- Arbitration, registered on the next edge:
  - Only set_req: S=1.
  - Only clr_req: R=1.
  - Both: the winner per PRIO_SET is asserted, the loser is suppressed, conflict=1.
  - Neither: S=R=conflict=0.
- Invariant: S & R is never 1 in any cycle, including during and after reset.
- Latency: raw input first sampled high at edge k gives S/R high after edge k+DEB_CYCLES+2 (edge k+6 for the default).
  - PULSE=1: output is exactly 1 cycle wide.
  - PULSE=0: output holds until the debounced release, and falls DEB_CYCLES+2 edges after the first low sample.
- Glitches: a high run shorter than DEB_CYCLES synchronised cycles produces no output and returns the FSM to IDLE. A low glitch while HIGH (shorter than DEB_CYCLES) produces no release.
- PULSE=1 re-trigger: a new pulse needs a full debounced release (back to IDLE) followed by a new press. Holding the button gives exactly one pulse.
- Simultaneous events:
  - A rise on one channel while the other channel is merely held (deb) in PULSE=1 is not a conflict; only coincident req counts.
  - PULSE=0, both held: winner held continuously, conflict held high.
  - When the winner releases, the loser is asserted on the next edge if it is still held.
- Reset mid-operation: all debounce progress is discarded. A button still held after reset release must complete a full debounce and then produces a fresh press (PULSE=1: one pulse).

Decomposition:
- Shared package `sr_pkg` holds:
  - the debounce state encoding (IDLE=2'd0, CHK_HI=2'd1, HIGH=2'd2, CHK_LO=2'd3);
  - the default DEB_CYCLES and CNT_W constants.
- One sub-module, `btn_debounce`: synchroniser plus FSM plus counter; outputs deb and rise. Instantiated twice.
- Arbitration and the output registers live in the top level.

Test Plan:
- Reset, then set_btn held high from edge 10 (DEB_CYCLES=4, PULSE=1) -> S=1 for exactly one cycle after edge 16; R=0 and conflict=0 throughout.
- Bounce: set_btn high for 2 cycles, low for 1, then high for 3, then low -> no S pulse; FSM back in IDLE.
- Both buttons rise on the same edge, PRIO_SET=0 -> R=1 and conflict=1 for one cycle, S stays 0. Repeat with PRIO_SET=1 -> S=1, R=0, conflict=1.
- PULSE=0, clr_btn held 20 cycles, then set_btn also held -> R stays 1 and conflict rises. After clr_btn is released and debounced, R=0 and S=1 on the same edge; S=R=1 never appears.
- rst pulled low 3 cycles after set_btn rises, released while set_btn is still high -> S=R=0 immediately during reset; after release, exactly one S pulse DEB_CYCLES+2 edges after the first post-reset sample.
- Held button, PULSE=1, 30 cycles -> exactly one S pulse. Release (debounced) and press again -> a second single pulse.
